// File: rtl/cap_dout.sv
// Serial capture of a DUT's dout into a word FIFO, read by a four-phase host handshake.
// Optional CAP_STATUS_EN compiles in the fn=3 status read (count/armed/ovf).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req with a matching id
// EXEC     | one cycle: perform fn, load rdata/rerr
// ACK      | ack=1, response held until host drops req
// WAIT_LOW | one-cycle gap before accepting the next request
module cap_dout #(
    parameter int ID    = 0,
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dout,
    input  logic        req,
    input  logic [7:0]  id,
    input  logic [1:0]  fn,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        rerr
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [5:0]     LAST_BIT = 6'(WIDTH - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = (AW)'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK, S_WAIT_LOW} state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic              armed_q, armed_d;
    logic              ovf_q, ovf_d;
    logic [5:0]        bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              req_block_q, req_block_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [WIDTH-1:0]  word;
    logic [31:0]       rd_word;
    logic              push, push_ok, pop, arm_cmd, disarm_cmd;

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;
        armed_d     = armed_q;
        ovf_d       = ovf_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        req_block_d = req_block_q & req;
        word        = shreg_q;
        rd_word     = '0;
        push        = 1'b0;
        push_ok     = 1'b0;
        pop         = 1'b0;
        arm_cmd     = 1'b0;
        disarm_cmd  = 1'b0;

        if (armed_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bitcnt_q == 6'(i)) word[i] = dout;
            end
            shreg_d = word;
            if (bitcnt_q == LAST_BIT) begin
                push     = 1'b1;
                bitcnt_d = 6'd0;
            end else begin
                bitcnt_d = bitcnt_q + 6'd1;
            end
        end

        rd_word[WIDTH-1:0] = mem[rd_ptr_q];

        case (state_q)
            S_IDLE: begin
                if (req && !req_block_q && id == 8'(ID)) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_ACK;
                ack_d   = 1'b1;
                rdata_d = '0;
                rerr_d  = 1'b0;
                case (fn)
                    2'd0: begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            rdata_d = rd_word;
                        end else begin
                            rerr_d = 1'b1;
                        end
                    end
                    2'd1: arm_cmd = 1'b1;
                    2'd2: disarm_cmd = 1'b1;
                    default: begin
`ifdef CAP_STATUS_EN
                        rdata_d = {22'd0, ovf_q, armed_q, 8'(count_q)};
`else
                        rerr_d = 1'b1;
`endif
                    end
                endcase
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_WAIT_LOW;
                    ack_d   = 1'b0;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
        push_ok = push && (count_q != FULL_CNT || pop);
        if (push && !push_ok) ovf_d = 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Restart is applied after the capture so a completing word still lands first.
        if (arm_cmd) begin
            armed_d  = 1'b1;
            ovf_d    = 1'b0;
            bitcnt_d = 6'd0;
            shreg_d  = '0;
        end
        if (disarm_cmd) begin
            armed_d  = 1'b0;
            bitcnt_d = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            armed_q     <= 1'b0;
            ovf_q       <= 1'b0;
            bitcnt_q    <= 6'd0;
            shreg_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            // A req still high across reset must drop before it can be served.
            req_block_q <= req;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
            armed_q     <= armed_d;
            ovf_q       <= ovf_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            req_block_q <= req_block_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr_q] <= word;
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign rerr  = rerr_q;

endmodule

// File: tb/tb_cap_dout.sv
// Scoreboard bench for cap_dout: two instances (WIDTH=8/DEPTH=2 and WIDTH=4/DEPTH=2).
// Expected responses are queued at request time and checked when ack rises.
module tb_cap_dout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dout_s  [2];
    logic        req_s   [2];
    logic [7:0]  id_s    [2];
    logic [1:0]  fn_s    [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        rerr_s  [2];
    logic        ack_prev[2];

    int n_vec = 0;
    int n_bad = 0;

    logic [32:0] exp_q [2][$];
    string       nm_q  [2][$];

    cap_dout #(.ID(0), .WIDTH(8), .DEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .dout(dout_s[0]), .req(req_s[0]), .id(id_s[0]),
        .fn(fn_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]), .rerr(rerr_s[0]));

    cap_dout #(.ID(3), .WIDTH(4), .DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .dout(dout_s[1]), .req(req_s[1]), .id(id_s[1]),
        .fn(fn_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]), .rerr(rerr_s[1]));

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {rerr, rdata} for a status read
    function automatic logic [32:0] status_exp(input int cnt, input logic armed, input logic ovf);
        logic [32:0] r;
        r      = '0;
        r[7:0] = 8'(cnt);
        r[8]   = armed;
        r[9]   = ovf;
`ifndef CAP_STATUS_EN
        r = {1'b1, 32'd0};
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack_s[d] === 1'b1 && ack_prev[d] !== 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    check($sformatf("unexpected_ack_d%0d", d), 33'd1, 33'd0);
                end else begin
                    check(nm_q[d].pop_front(), {rerr_s[d], rdata_s[d]}, exp_q[d].pop_front());
                end
            end
            if (ack_s[d] === 1'b0) begin
                check($sformatf("idle_zero_d%0d", d), {rerr_s[d], rdata_s[d]}, 33'd0);
            end
            ack_prev[d] = ack_s[d];
        end
    end

    // Starts at a falling edge; returns four falling edges later with the FSM back in IDLE.
    task automatic do_req(input int d, input logic [7:0] idv, input logic [1:0] fnv,
                          input logic [32:0] exp, input string name);
        int cyc;
        exp_q[d].push_back(exp);
        nm_q[d].push_back(name);
        id_s[d]  = idv;
        fn_s[d]  = fnv;
        req_s[d] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack_s[d] !== 1'b1 && cyc < 20);
        check({"lat_", name}, 33'(cyc), 33'd2);
        req_s[d] = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack_s[d] !== 1'b0 && cyc < 20);
        check({"drop_", name}, 33'(cyc), 33'd1);
        @(negedge clk);
    endtask

    // First bit lands two falling edges after the arm request, i.e. the cycle after arm commits.
    task automatic stream(input int d, input logic [31:0] bits, input int n);
        repeat (2) @(negedge clk);
        dout_s[d] = bits[0];
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            dout_s[d] = bits[i];
        end
        @(negedge clk);
        dout_s[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            dout_s[d] = 1'b0; req_s[d] = 1'b0; id_s[d] = 8'd0; fn_s[d] = 2'd0;
            ack_prev[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_ack0", {32'd0, ack_s[0]}, 33'd0);
        check("reset_ack1", {32'd0, ack_s[1]}, 33'd0);
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=8, DEPTH=2, ID=0
        do_req(0, 8'd0, 2'd0, {1'b1, 32'd0}, "pop_empty");
        fork
            do_req(0, 8'd0, 2'd1, 33'd0, "arm8");
            stream(0, 32'h0000_000D, 8);
        join
        do_req(0, 8'd0, 2'd2, 33'd0, "disarm8");
        do_req(0, 8'd0, 2'd0, {1'b0, 32'h0D}, "pop_0d");
        do_req(0, 8'd0, 2'd0, {1'b1, 32'd0}, "pop_empty2");
        do_req(0, 8'd0, 2'd3, status_exp(0, 1'b0, 1'b0), "stat_idle");
        fork
            do_req(0, 8'd0, 2'd1, 33'd0, "arm24");
            stream(0, 32'h00FF_3CA5, 24);
        join
        do_req(0, 8'd0, 2'd3, status_exp(2, 1'b1, 1'b1), "stat_ovf");
        do_req(0, 8'd0, 2'd1, 33'd0, "rearm");
        do_req(0, 8'd0, 2'd3, status_exp(2, 1'b1, 1'b0), "stat_rearm");
        do_req(0, 8'd0, 2'd0, {1'b0, 32'hA5}, "pop_full_push1");
        do_req(0, 8'd0, 2'd3, status_exp(2, 1'b1, 1'b0), "stat_pp1");
        do_req(0, 8'd0, 2'd0, {1'b0, 32'h3C}, "pop_full_push2");
        do_req(0, 8'd0, 2'd2, 33'd0, "disarm24");
        do_req(0, 8'd0, 2'd3, status_exp(2, 1'b0, 1'b0), "stat_dis");
        do_req(0, 8'd0, 2'd0, {1'b0, 32'h00}, "pop_zero_a");
        do_req(0, 8'd0, 2'd0, {1'b0, 32'h00}, "pop_zero_b");
        do_req(0, 8'd0, 2'd0, {1'b1, 32'd0}, "pop_empty3");

        // WIDTH=4, DEPTH=2, ID=3
        fork
            do_req(1, 8'd3, 2'd1, 33'd0, "arm4");
            stream(1, 32'h0000_0F35, 12);
        join
        do_req(1, 8'd3, 2'd3, status_exp(2, 1'b1, 1'b1), "stat1_ovf");
        id_s[1] = 8'd4; fn_s[1] = 2'd0; req_s[1] = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_s[1] !== 1'b0) acks++;
        end
        check("bad_id_no_ack", 33'(acks), 33'd0);
        req_s[1] = 1'b0;
        repeat (2) @(negedge clk);
        do_req(1, 8'd3, 2'd3, status_exp(2, 1'b1, 1'b1), "stat1_after_bad_id");
        do_req(1, 8'd3, 2'd0, {1'b0, 32'h5}, "pop1_a");
        do_req(1, 8'd3, 2'd0, {1'b0, 32'h3}, "pop1_b");
        do_req(1, 8'd3, 2'd2, 33'd0, "disarm4");

        // reset while ack is high
        exp_q[1].push_back(33'd0);
        nm_q[1].push_back("arm_before_rst");
        id_s[1] = 8'd3; fn_s[1] = 2'd1; req_s[1] = 1'b1;
        acks = 0;
        do begin @(negedge clk); acks++; end while (ack_s[1] !== 1'b1 && acks < 20);
        check("rst_pre_ack", {32'd0, ack_s[1]}, 33'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ack_drop", {32'd0, ack_s[1]}, 33'd0);
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack_s[1] !== 1'b0) acks++;
        end
        check("rst_req_held_no_ack", 33'(acks), 33'd0);
        req_s[1] = 1'b0;
        repeat (2) @(negedge clk);
        do_req(1, 8'd3, 2'd3, status_exp(0, 1'b0, 1'b0), "stat1_post_rst");
        do_req(0, 8'd0, 2'd3, status_exp(0, 1'b0, 1'b0), "stat0_post_rst");
        do_req(0, 8'd0, 2'd0, {1'b1, 32'd0}, "pop0_post_rst");

        check("queues_drained", 33'(exp_q[0].size() + exp_q[1].size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
